// File: rtl/gfx256_pixel_writer.sv
// Pixel write combiner: gathers 8/16/24/32bpp pixel writes into a 32-byte line
// buffer and emits each line as a single 256-bit Wishbone write.
module gfx256_pixel_writer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         pix_valid_i,
  output logic         pix_ready_o,
  input  logic [31:0]  pix_adr_i,
  input  logic [31:0]  color_i,
  input  logic [1:0]   color_depth_i,
  input  logic         flush_i,
  output logic         idle_o,
  output logic         cyc_o,
  output logic         stb_o,
  output logic         we_o,
  output logic [31:0]  adr_o,
  output logic [255:0] dat_o,
  output logic [31:0]  sel_o,
  input  logic         ack_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_WRITE
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t state;
  state_t state_next;

  logic [26:0]  tag;
  logic [255:0] data;
  logic [31:0]  sel;
  logic [7:0]   idle_cnt;

  logic [26:0]  pix_tag;
  logic [7:0]   mb;
  logic         tag_hit;
  logic         timed_out;
  logic         accept;
  logic         start_write;

  logic [31:0]  color_mask;
  logic [31:0]  byte_ones;
  logic [255:0] color_line;
  logic [255:0] mask_line;
  logic [31:0]  sel_bits;
  logic [255:0] base_data;
  logic [31:0]  base_sel;
  logic [255:0] merged_data;
  logic [31:0]  merged_sel;

  assign pix_tag   = pix_adr_i[31:5];
  assign mb        = {pix_adr_i[4:0], 3'b000};
  assign tag_hit   = (pix_tag == tag);
  assign timed_out = (idle_cnt >= TIMEOUT_CNT);
  assign accept    = pix_valid_i && pix_ready_o;

  // Colour mask and byte-enable pattern for the selected depth
  always_comb begin
    color_mask = '1;
    byte_ones  = 32'h0000_000F;
    unique case (color_depth_i)
      2'd0: begin
        color_mask = 32'h0000_00FF;
        byte_ones  = 32'h0000_0001;
      end
      2'd1: begin
        color_mask = 32'h0000_FFFF;
        byte_ones  = 32'h0000_0003;
      end
      2'd2: begin
        color_mask = 32'h00FF_FFFF;
        byte_ones  = 32'h0000_0007;
      end
      2'd3: begin
        color_mask = 32'hFFFF_FFFF;
        byte_ones  = 32'h0000_000F;
      end
    endcase
  end

  // Left shifts within the line width drop anything past byte 31
  always_comb begin
    color_line  = {224'b0, color_i & color_mask} << mb;
    mask_line   = {224'b0, color_mask} << mb;
    sel_bits    = byte_ones << pix_adr_i[4:0];
    base_data   = (state == S_IDLE) ? '0 : data;
    base_sel    = (state == S_IDLE) ? '0 : sel;
    merged_data = color_line | (base_data & ~mask_line);
    merged_sel  = base_sel | sel_bits;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pix_ready_o = 1'b0;
    idle_o      = 1'b0;
    start_write = 1'b0;
    case (state)
      S_IDLE: begin
        pix_ready_o = 1'b1;
        idle_o      = 1'b1;
        if (pix_valid_i) begin
          state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        pix_ready_o = tag_hit && !flush_i && !timed_out;
        if (flush_i || (pix_valid_i && !tag_hit) || timed_out) begin
          start_write = 1'b1;
          state_next  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (ack_i) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (rst_i) begin
      pix_ready_o = 1'b0;
      idle_o      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag      <= '0;
      data     <= '0;
      sel      <= '0;
      idle_cnt <= '0;
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
      we_o     <= 1'b0;
      adr_o    <= '0;
      dat_o    <= '0;
      sel_o    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            tag      <= pix_tag;
            data     <= merged_data;
            sel      <= merged_sel;
            idle_cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            data     <= merged_data;
            sel      <= merged_sel;
            idle_cnt <= '0;
          end else if (start_write) begin
            idle_cnt <= '0;
            cyc_o    <= 1'b1;
            stb_o    <= 1'b1;
            we_o     <= 1'b1;
            adr_o    <= {tag, 5'b00000};
            dat_o    <= data;
            sel_o    <= sel;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        S_WRITE: begin
          if (ack_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            sel_o <= '0;
            sel   <= '0;
          end
        end
        default: begin
          idle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx256_pixel_writer.sv
// Self-checking bench for gfx256_pixel_writer: directed scenarios plus random
// line traffic checked against a byte-array model of the line buffer.
module tb_gfx256_pixel_writer;

  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         pix_valid_i = 1'b0;
  logic         pix_ready_o;
  logic [31:0]  pix_adr_i = '0;
  logic [31:0]  color_i = '0;
  logic [1:0]   color_depth_i = '0;
  logic         flush_i = 1'b0;
  logic         idle_o;
  logic         cyc_o, stb_o, we_o;
  logic [31:0]  adr_o;
  logic [255:0] dat_o;
  logic [31:0]  sel_o;
  logic         ack_i = 1'b0;

  int checks = 0;
  int failures = 0;

  gfx256_pixel_writer #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .pix_adr_i(pix_adr_i), .color_i(color_i), .color_depth_i(color_depth_i),
    .flush_i(flush_i), .idle_o(idle_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Line model: one byte and one enable per byte lane of the 32-byte line
  logic [7:0] m_byte [32];
  bit         m_en   [32];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_byte[i] = 8'h00;
      m_en[i]   = 1'b0;
    end
  endtask

  task automatic model_merge(input logic [31:0] adr, input logic [31:0] col, input logic [1:0] dep);
    for (int i = 0; i <= int'(dep); i++) begin
      int p;
      p = int'(adr[4:0]) + i;
      if (p < 32) begin
        m_byte[p] = col[8*i +: 8];
        m_en[p]   = 1'b1;
      end
    end
  endtask

  function automatic logic [255:0] model_dat();
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[8*i +: 8] = m_byte[i];
    return d;
  endfunction

  function automatic logic [31:0] model_sel();
    logic [31:0] s;
    for (int i = 0; i < 32; i++) s[i] = m_en[i];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [31:0] adr, input logic [31:0] col, input logic [1:0] dep);
    int n;
    n = 0;
    pix_valid_i = 1'b1;
    pix_adr_i = adr;
    color_i = col;
    color_depth_i = dep;
    #1;
    while (!pix_ready_o && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL send_pixel_ready: ready=%0b required=1 within 100 cycles", pix_ready_o);
    end
    tick();
    pix_valid_i = 1'b0;
  endtask

  task automatic wait_stb();
    int n;
    n = 0;
    while (stb_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (stb_o !== 1'b1) begin
      failures++;
      $display("FAIL wait_stb: stb_o=%0b required=1 within 200 cycles", stb_o);
    end
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if (pix_ready_o !== 1'b0 || idle_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: ready=%0b idle=%0b required 0 0", pix_ready_o, idle_o);
    end
    checks++;
    if ({cyc_o, stb_o, we_o} !== 3'b000 || adr_o !== '0 || sel_o !== '0 || dat_o !== '0) begin
      failures++;
      $display("FAIL reset_bus: cyc/stb/we=%b adr=%h sel=%h required all zero", {cyc_o, stb_o, we_o}, adr_o, sel_o);
    end
    rst_i = 1'b0;
    tick();
    checks++;
    if (idle_o !== 1'b1 || pix_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: idle=%0b ready=%0b required 1 1", idle_o, pix_ready_o);
    end
  endtask

  task automatic test_pack_8bpp();
    for (int i = 0; i < 4; i++) send_pixel(32'h100 + 32'(i), 32'(8'h11 * (i + 1)), 2'd0);
    do_flush();
    wait_stb();
    checks++;
    if (adr_o !== 32'h100 || sel_o !== 32'h0000_000F || dat_o[31:0] !== 32'h4433_2211) begin
      failures++;
      $display("FAIL pack_8bpp: adr=%h sel=%h dat=%h required 100 0000000f 44332211", adr_o, sel_o, dat_o[31:0]);
    end
    do_ack();
    checks++;
    if (cyc_o !== 1'b0 || idle_o !== 1'b1) begin
      failures++;
      $display("FAIL pack_8bpp_ack: cyc=%0b idle=%0b required 0 1", cyc_o, idle_o);
    end
  endtask

  task automatic test_tag_mismatch();
    send_pixel(32'h1C, 32'hDEAD_BEEF, 2'd3);
    pix_valid_i = 1'b1;
    pix_adr_i = 32'h40;
    color_i = 32'h0000_5A5A;
    color_depth_i = 2'd1;
    #1;
    checks++;
    if (pix_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_ready: ready=%0b required 0", pix_ready_o);
    end
    tick();
    checks++;
    if (stb_o !== 1'b1 || adr_o !== 32'h0 || sel_o !== 32'hF000_0000 || dat_o[255:224] !== 32'hDEAD_BEEF || pix_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_write: stb=%0b adr=%h sel=%h top=%h ready=%0b required 1 0 f0000000 deadbeef 0",
               stb_o, adr_o, sel_o, dat_o[255:224], pix_ready_o);
    end
    do_ack();
    checks++;
    if (cyc_o !== 1'b0 || pix_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL mismatch_after_ack: cyc=%0b ready=%0b required 0 1", cyc_o, pix_ready_o);
    end
    tick();
    pix_valid_i = 1'b0;
    checks++;
    if (idle_o !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_accept: idle=%0b required 0", idle_o);
    end
    do_flush();
    wait_stb();
    checks++;
    if (adr_o !== 32'h40 || sel_o !== 32'h0000_0003 || dat_o[15:0] !== 16'h5A5A) begin
      failures++;
      $display("FAIL mismatch_second: adr=%h sel=%h dat=%h required 40 00000003 5a5a", adr_o, sel_o, dat_o[15:0]);
    end
    do_ack();
  endtask

  task automatic test_truncate();
    send_pixel(32'h3E, 32'h00AA_BBCC, 2'd2);
    do_flush();
    wait_stb();
    checks++;
    if (adr_o !== 32'h20 || sel_o !== 32'hC000_0000 || dat_o[255:240] !== 16'hBBCC || dat_o[239:0] !== '0) begin
      failures++;
      $display("FAIL truncate: adr=%h sel=%h top=%h required 20 c0000000 bbcc", adr_o, sel_o, dat_o[255:240]);
    end
    do_ack();
  endtask

  task automatic test_overlap();
    send_pixel(32'h20, 32'h1234, 2'd1);
    send_pixel(32'h20, 32'hABCD, 2'd1);
    do_flush();
    wait_stb();
    checks++;
    if (adr_o !== 32'h20 || sel_o !== 32'h0000_0003 || dat_o[15:0] !== 16'hABCD) begin
      failures++;
      $display("FAIL overlap: adr=%h sel=%h dat=%h required 20 00000003 abcd", adr_o, sel_o, dat_o[15:0]);
    end
    do_ack();
  endtask

  task automatic test_flush_priority();
    send_pixel(32'h200, 32'h77, 2'd0);
    pix_valid_i = 1'b1;
    pix_adr_i = 32'h201;
    color_i = 32'h88;
    color_depth_i = 2'd0;
    flush_i = 1'b1;
    #1;
    checks++;
    if (pix_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_prio_ready: ready=%0b required 0", pix_ready_o);
    end
    tick();
    flush_i = 1'b0;
    pix_valid_i = 1'b0;
    wait_stb();
    checks++;
    if (sel_o !== 32'h1 || dat_o[15:0] !== 16'h0077) begin
      failures++;
      $display("FAIL flush_prio_write: sel=%h dat=%h required 00000001 0077", sel_o, dat_o[15:0]);
    end
    do_ack();
  endtask

  task automatic test_flush_idle();
    flush_i = 1'b1;
    tick();
    tick();
    flush_i = 1'b0;
    tick();
    checks++;
    if (idle_o !== 1'b1 || cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: idle=%0b cyc=%0b required 1 0", idle_o, cyc_o);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] adr, col;
    logic [1:0]  dep;
    int n;
    adr = $urandom;
    col = $urandom;
    dep = 2'($urandom_range(0, 3));
    model_clear();
    model_merge(adr, col, dep);
    send_pixel(adr, col, dep);
    n = 0;
    while (stb_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != TO + 1) begin
      failures++;
      $display("FAIL timeout_cycles: stb after %0d cycles required %0d", n, TO + 1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({cyc_o, stb_o, we_o} !== 3'b111 || pix_ready_o !== 1'b0 || adr_o !== (adr & ~32'h1F) ||
          sel_o !== model_sel() || dat_o !== model_dat()) begin
        failures++;
        $display("FAIL timeout_hold[%0d]: cyc/stb/we=%b adr=%h sel=%h required 111 %h %h",
                 i, {cyc_o, stb_o, we_o}, adr_o, sel_o, adr & ~32'h1F, model_sel());
      end
    end
    do_ack();
  endtask

  task automatic test_reset_mid_write();
    int seen;
    send_pixel(32'h1234_5600, 32'h99, 2'd0);
    do_flush();
    wait_stb();
    rst_i = 1'b1;
    tick();
    checks++;
    if (cyc_o !== 1'b0 || idle_o !== 1'b0 || pix_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_write: cyc=%0b idle=%0b ready=%0b required 0 0 0", cyc_o, idle_o, pix_ready_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (idle_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_release: idle=%0b required 1", idle_o);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (stb_o === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_mid_discard: stb cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_random_lines();
    for (int it = 0; it < 8; it++) begin
      logic [31:0] base;
      int unsigned np;
      base = $urandom & ~32'h1F;
      np = $urandom_range(1, 10);
      model_clear();
      for (int unsigned k = 0; k < np; k++) begin
        logic [31:0] adr, col;
        logic [1:0]  dep;
        int unsigned gap;
        adr = base | 32'($urandom_range(0, 31));
        col = $urandom;
        dep = 2'($urandom_range(0, 3));
        gap = $urandom_range(0, 3);
        for (int unsigned g = 0; g < gap; g++) tick();
        model_merge(adr, col, dep);
        send_pixel(adr, col, dep);
      end
      do_flush();
      wait_stb();
      checks++;
      if (adr_o !== base || sel_o !== model_sel() || dat_o !== model_dat()) begin
        failures++;
        $display("FAIL random_line[%0d]: adr=%h sel=%h dat=%h required %h %h %h",
                 it, adr_o, sel_o, dat_o, base, model_sel(), model_dat());
      end
      do_ack();
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      logic [31:0] line_a, line_b, adr_b, col_b;
      logic [1:0]  dep_b;
      line_a = $urandom & ~32'h1F;
      line_b = line_a ^ (32'($urandom_range(1, 255)) << 5);
      model_clear();
      for (int k = 0; k < 3; k++) begin
        logic [31:0] adr, col;
        logic [1:0]  dep;
        adr = line_a | 32'($urandom_range(0, 31));
        col = $urandom;
        dep = 2'($urandom_range(0, 3));
        model_merge(adr, col, dep);
        send_pixel(adr, col, dep);
      end
      adr_b = line_b | 32'($urandom_range(0, 31));
      col_b = $urandom;
      dep_b = 2'($urandom_range(0, 3));
      pix_valid_i = 1'b1;
      pix_adr_i = adr_b;
      color_i = col_b;
      color_depth_i = dep_b;
      wait_stb();
      checks++;
      if (adr_o !== line_a || sel_o !== model_sel() || dat_o !== model_dat()) begin
        failures++;
        $display("FAIL b2b_first[%0d]: adr=%h sel=%h required %h %h", it, adr_o, sel_o, line_a, model_sel());
      end
      do_ack();
      checks++;
      if (pix_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: ready=%0b required 1", it, pix_ready_o);
      end
      model_clear();
      model_merge(adr_b, col_b, dep_b);
      send_pixel(adr_b, col_b, dep_b);
      do_flush();
      wait_stb();
      checks++;
      if (adr_o !== line_b || sel_o !== model_sel() || dat_o !== model_dat()) begin
        failures++;
        $display("FAIL b2b_second[%0d]: adr=%h sel=%h required %h %h", it, adr_o, sel_o, line_b, model_sel());
      end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_flush_idle();
    test_pack_8bpp();
    test_tag_mismatch();
    test_truncate();
    test_overlap();
    test_flush_priority();
    test_timeout();
    test_reset_mid_write();
    test_random_lines();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
